// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine: one shared shift-add datapath stepped ITER times per operand,
// with valid/ready handshakes on both sides.
module cordic_iter_ctrl #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z,
  output logic        busy
);

  localparam logic [4:0] LastIdx = 5'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [31:0]        out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;

  logic signed [31:0] x_shift, y_shift, x_nxt, y_nxt, z_nxt, atan_i;
  logic               z_pos;

  // round(atan(2^-i) * 2^30); past i=10 the value is exactly 2^(30-i).
  function automatic logic [31:0] atan_rom(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd0:    v = 32'h3243F6A9;
      5'd1:    v = 32'h1DAC6705;
      5'd2:    v = 32'h0FADBAFD;
      5'd3:    v = 32'h07F56EA7;
      5'd4:    v = 32'h03FEAB77;
      5'd5:    v = 32'h01FFD55C;
      5'd6:    v = 32'h00FFFAAB;
      5'd7:    v = 32'h007FFF55;
      5'd8:    v = 32'h003FFFEB;
      5'd9:    v = 32'h001FFFFD;
      5'd31:   v = 32'h00000000;
      default: v = 32'h40000000 >> i;
    endcase
    return v;
  endfunction

  assign atan_i  = atan_rom(cnt_q);
  assign x_shift = x_q >>> cnt_q;
  assign y_shift = y_q >>> cnt_q;
  // z == 0 deliberately takes the negative-rotation branch.
  assign z_pos   = (z_q > 32'sd0);
  assign x_nxt   = z_pos ? (x_q - y_shift) : (x_q + y_shift);
  assign y_nxt   = z_pos ? (y_q + x_shift) : (y_q - x_shift);
  assign z_nxt   = z_pos ? (z_q - atan_i)  : (z_q + atan_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    out_z_d = out_z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          z_d     = in_z;
          cnt_d   = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d = x_nxt;
        y_d = y_nxt;
        z_d = z_nxt;
        if (cnt_q == LastIdx) begin
          out_x_d = x_nxt;
          out_y_d = y_nxt;
          out_z_d = z_nxt;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_z_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      out_z_q <= out_z_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: ITER=16 instance for the main scenarios, ITER=1 instance
// for the z==0 direction tie.
module tb_cordic_iter_ctrl;

  localparam logic [31:0] KX   = 32'h26DD3B6A;
  localparam logic [31:0] Z30  = 32'h2182A470;
  localparam logic [31:0] ZM30 = 32'hDE7D5B90;
  localparam longint      Tol  = 64'sd65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_x, in_y, in_z, out_x, out_y, out_z;
  logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_busy;
  logic [31:0] t_in_x, t_in_y, t_in_z, t_out_x, t_out_y, t_out_z;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] atan_tb [0:30];

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.ITER(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .busy(busy)
  );

  cordic_iter_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_x(t_in_x),
    .in_y(t_in_y), .in_z(t_in_z), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_x(t_out_x), .out_y(t_out_y), .out_z(t_out_z), .busy(t_busy)
  );

  // Reference: the rotation recurrence with an angle table built from $atan.
  function automatic void model(input logic [31:0] x0, input logic [31:0] y0,
                                input logic [31:0] z0, input int n, output logic [31:0] xo,
                                output logic [31:0] yo, output logic [31:0] zo);
    logic signed [31:0] x, y, z, xs, ys;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z > 32'sd0) begin x = x - ys; y = y + xs; z = z - atan_tb[i]; end
      else            begin x = x + ys; y = y - xs; z = z + atan_tb[i]; end
    end
    xo = x; yo = y; zo = z;
  endfunction

  function automatic longint sdiff(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d < 0) ? -d : d;
  endfunction

  // Present one operand, wait for acceptance, return the result and edges-to-out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        output int lat);
    int n;
    @(negedge clk);
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic release_out;
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    t_in_valid = 1'b0; t_out_ready = 1'b0; t_in_x = '0; t_in_y = '0; t_in_z = '0;
    #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if ({out_x, out_y, out_z} !== 96'h0) begin n_err++; $display("FAIL reset_outputs got %h %h %h want 0", out_x, out_y, out_z); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_angle;
    int lat;
    logic [31:0] ex, ey, ez;
    model(KX, 32'h0, 32'h0, 16, ex, ey, ez);
    run_op(KX, 32'h0, 32'h0, lat);
    n_vec++; if (lat !== 16) begin n_err++; $display("FAIL zero_latency got %0d want 16", lat); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy_done got %b want 1", busy); end
    n_vec++; if ({out_x, out_y, out_z} !== {ex, ey, ez}) begin n_err++; $display("FAIL zero_result got %h %h %h want %h %h %h", out_x, out_y, out_z, ex, ey, ez); end
    n_vec++; if (sdiff(out_x, 32'h40000000) >= Tol || sdiff(out_y, 32'h0) >= Tol || sdiff(out_z, 32'h0) >= Tol) begin
      n_err++; $display("FAIL zero_accuracy got %h %h %h want ~40000000 ~0 ~0", out_x, out_y, out_z); end
    release_out();
  endtask

  task automatic test_pi6;
    int lat;
    logic [31:0] ex, ey, ez;
    model(KX, 32'h0, Z30, 16, ex, ey, ez);
    run_op(KX, 32'h0, Z30, lat);
    n_vec++; if ({out_x, out_y, out_z} !== {ex, ey, ez}) begin n_err++; $display("FAIL pi6_result got %h %h %h want %h %h %h", out_x, out_y, out_z, ex, ey, ez); end
    // 16 iterations leave up to ~2^15 LSB of residual angle, so sin/cos are only near-exact.
    n_vec++; if (sdiff(out_x, 32'h376CF5D1) >= Tol || sdiff(out_y, 32'h20000000) >= Tol) begin
      n_err++; $display("FAIL pi6_sincos got %h %h want ~376CF5D1 ~20000000", out_x, out_y); end
    release_out();
    model(KX, 32'h0, ZM30, 16, ex, ey, ez);
    run_op(KX, 32'h0, ZM30, lat);
    n_vec++; if ({out_x, out_y, out_z} !== {ex, ey, ez}) begin n_err++; $display("FAIL mpi6_result got %h %h %h want %h %h %h", out_x, out_y, out_z, ex, ey, ez); end
    n_vec++; if (sdiff(out_x, 32'h376CF5D1) >= Tol || sdiff(out_y, 32'hE0000000) >= Tol) begin
      n_err++; $display("FAIL mpi6_sincos got %h %h want ~376CF5D1 ~E0000000", out_x, out_y); end
    release_out();
  endtask

  task automatic test_backpressure;
    int lat, bad_v, bad_d, bad_r;
    logic [31:0] rx, ry, rz, ex, ey, ez;
    run_op(KX, 32'h0, 32'h10000000, lat);
    rx = out_x; ry = out_y; rz = out_z;
    @(negedge clk);
    in_x = KX; in_y = 32'h0; in_z = 32'hF8000000; in_valid = 1'b1;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_v++;
      if ({out_x, out_y, out_z} !== {rx, ry, rz}) bad_d++;
      if (in_ready !== 1'b0) bad_r++;
    end
    n_vec++; if (bad_v != 0) begin n_err++; $display("FAIL bp_valid_held got %0d drops want 0", bad_v); end
    n_vec++; if (bad_d != 0) begin n_err++; $display("FAIL bp_data_stable got %0d changes want 0", bad_d); end
    n_vec++; if (bad_r != 0) begin n_err++; $display("FAIL bp_in_ready_low got %0d highs want 0", bad_r); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    n_vec++; if (out_x !== rx) begin n_err++; $display("FAIL bp_data_retained got %h want %h", out_x, rx); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    model(KX, 32'h0, 32'hF8000000, 16, ex, ey, ez);
    n_vec++; if (lat !== 16) begin n_err++; $display("FAIL bp_second_latency got %0d want 16", lat); end
    n_vec++; if ({out_x, out_y, out_z} !== {ex, ey, ez}) begin n_err++; $display("FAIL bp_second_result got %h %h %h want %h %h %h", out_x, out_y, out_z, ex, ey, ez); end
    release_out();
  endtask

  task automatic test_back_to_back;
    logic [31:0] zs [3];
    logic [31:0] bx [3];
    logic [31:0] by [3];
    logic [31:0] bz [3];
    logic [31:0] ex, ey, ez;
    int cyc [3];
    int sent, got;
    logic acc;
    zs[0] = 32'h10000000; zs[1] = 32'hF0000000; zs[2] = 32'h08000000;
    @(negedge clk);
    in_x = KX; in_y = 32'h0; in_z = zs[0]; in_valid = 1'b1; out_ready = 1'b1;
    sent = 0; got = 0;
    acc = in_ready;
    for (int c = 0; c < 200 && got < 3; c++) begin
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent < 3) in_z = zs[sent];
        else in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (out_valid) begin bx[got] = out_x; by[got] = out_y; bz[got] = out_z; cyc[got] = c; got++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (got != 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", got); end
    for (int k = 0; k < got; k++) begin
      model(KX, 32'h0, zs[k], 16, ex, ey, ez);
      n_vec++; if ({bx[k], by[k], bz[k]} !== {ex, ey, ez}) begin n_err++; $display("FAIL b2b_result%0d got %h %h %h want %h %h %h", k, bx[k], by[k], bz[k], ex, ey, ez); end
    end
    // Period is ITER RUN cycles + one DONE cycle + one IDLE accept cycle.
    for (int k = 1; k < got; k++) begin
      n_vec++; if (cyc[k] - cyc[k-1] != 18) begin n_err++; $display("FAIL b2b_spacing%0d got %0d want 18", k, cyc[k] - cyc[k-1]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] ex, ey, ez;
    @(negedge clk);
    in_x = KX; in_y = 32'h0; in_z = Z30; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_flags got out_valid=%b busy=%b want 0 0", out_valid, busy); end
    n_vec++; if ({out_x, out_y, out_z} !== 96'h0) begin n_err++; $display("FAIL midrst_outputs got %h %h %h want 0", out_x, out_y, out_z); end
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    model(KX, 32'h0, ZM30, 16, ex, ey, ez);
    run_op(KX, 32'h0, ZM30, lat);
    n_vec++; if (lat !== 16 || {out_x, out_y, out_z} !== {ex, ey, ez}) begin
      n_err++; $display("FAIL midrst_next got lat=%0d %h %h %h want 16 %h %h %h", lat, out_x, out_y, out_z, ex, ey, ez); end
    release_out();
  endtask

  task automatic test_tie;
    @(negedge clk);
    t_in_x = 32'h40000000; t_in_y = 32'h0; t_in_z = 32'h0; t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    n_vec++; if (t_in_ready !== 1'b0 || t_busy !== 1'b1) begin n_err++; $display("FAIL tie_run got in_ready=%b busy=%b want 0 1", t_in_ready, t_busy); end
    @(negedge clk);
    n_vec++; if (t_out_valid !== 1'b1) begin n_err++; $display("FAIL tie_latency got out_valid=%b want 1", t_out_valid); end
    n_vec++; if ({t_out_x, t_out_y, t_out_z} !== {32'h40000000, 32'hC0000000, 32'h3243F6A9}) begin
      n_err++; $display("FAIL tie_result got %h %h %h want 40000000 C0000000 3243F6A9", t_out_x, t_out_y, t_out_z); end
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
    n_vec++; if (t_out_valid !== 1'b0 || t_in_ready !== 1'b1) begin n_err++; $display("FAIL tie_release got out_valid=%b in_ready=%b want 0 1", t_out_valid, t_in_ready); end
  endtask

  initial begin
    real r;
    r = 1.0;
    for (int i = 0; i < 31; i++) begin
      atan_tb[i] = 32'($rtoi($atan(r) * 1073741824.0 + 0.5));
      r = r / 2.0;
    end
    test_reset();
    test_zero_angle();
    test_pi6();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_tie();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
